// File: rtl/gpr_pkg.sv
// gpr_pkg: shared constants and types for the GPR write-back slice.
//   XLEN, NREG_BITS : data width and GPR address width.
//   F3_*            : RV64 load funct3 encodings.
//   src_e           : round-robin priority pointer (EXU or LSU).
package gpr_pkg;

  localparam int XLEN      = 64;
  localparam int NREG_BITS = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

endpackage

// File: rtl/gpr_writeback_load_extract.sv
// load_extract: purely combinational load-data extraction.
//   rdata   : raw aligned 8-byte memory word
//   addr_lo : byte offset of the load within the word
//   funct3  : RV64 load type
//   result  : shifted, truncated and sign/zero-extended load value
// No alignment check: the shift is applied exactly as given, with zero fill.
module load_extract
  import gpr_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] sh;

  assign sh = rdata >> {addr_lo, 3'b000};

  always_comb begin
    result = sh;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){sh[7]}},   sh[7:0]};
      F3_LH:   result = {{(XLEN-16){sh[15]}}, sh[15:0]};
      F3_LW:   result = {{(XLEN-32){sh[31]}}, sh[31:0]};
      F3_LD:   result = sh;
      F3_LBU:  result = {{(XLEN-8){1'b0}},    sh[7:0]};
      F3_LHU:  result = {{(XLEN-16){1'b0}},   sh[15:0]};
      F3_LWU:  result = {{(XLEN-32){1'b0}},   sh[31:0]};
      default: result = sh;  // 3'b111 behaves as LD
    endcase
  end

endmodule

// File: rtl/gpr_writeback.sv
// gpr_writeback: write-side driver for the 32x64 GPR file.
//   clock, reset            : clock; asynchronous active-high reset
//   exu_valid/ready/rd/data : EXU result channel
//   lsu_valid/ready/rd      : LSU load result channel
//   lsu_rdata/addr_lo/funct3: raw load word, byte offset, load type
//   wen, wAddr, wData       : registered GPR write port
//   retire_cnt              : number of accepted results (wraps at 2^64)
//
// Handshake: a result transfers in a cycle where its valid and ready are both
// high. Sources hold valid/rd/data stable until ready. ready is a purely
// combinational grant from the arbiter, independent of wen; at most one of
// exu_ready/lsu_ready is high. An accepted result appears on wen/wAddr/wData
// in the following cycle; rd==0 results retire but never raise wen.
module gpr_writeback
  import gpr_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 exu_valid,
  output logic                 exu_ready,
  input  logic [NREG_BITS-1:0] exu_rd,
  input  logic [XLEN-1:0]      exu_data,
  input  logic                 lsu_valid,
  output logic                 lsu_ready,
  input  logic [NREG_BITS-1:0] lsu_rd,
  input  logic [XLEN-1:0]      lsu_rdata,
  input  logic [2:0]           lsu_addr_lo,
  input  logic [2:0]           lsu_funct3,
  output logic                 wen,
  output logic [NREG_BITS-1:0] wAddr,
  output logic [XLEN-1:0]      wData,
  output logic [63:0]          retire_cnt
);

  src_e            prio;
  logic [XLEN-1:0] load_data;

  load_extract u_load_extract (
    .rdata   (lsu_rdata),
    .addr_lo (lsu_addr_lo),
    .funct3  (lsu_funct3),
    .result  (load_data)
  );

  // A lone requester always wins; on a conflict prio decides. Since prio then
  // flips to the loser, a still-valid loser wins the very next cycle.
  assign exu_ready = exu_valid && (!lsu_valid || (prio == SRC_EXU));
  assign lsu_ready = lsu_valid && (!exu_valid || (prio == SRC_LSU));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wen        <= 1'b0;
      wAddr      <= '0;
      wData      <= '0;
      retire_cnt <= '0;
      prio       <= SRC_EXU;
    end else begin
      wen <= 1'b0;
      if (exu_ready) begin
        wen        <= (exu_rd != '0);
        wAddr      <= exu_rd;
        wData      <= exu_data;
        retire_cnt <= retire_cnt + 64'd1;
        prio       <= SRC_LSU;
      end else if (lsu_ready) begin
        wen        <= (lsu_rd != '0);
        wAddr      <= lsu_rd;
        wData      <= load_data;
        retire_cnt <= retire_cnt + 64'd1;
        prio       <= SRC_EXU;
      end
    end
  end

endmodule
